// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus bundle between the CPU master port and avalon_wait_ram.
// Carries the address, data and handshake signals; clock and reset stay outside.
interface avalon_wait_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_wait_ram.sv
// Avalon-MM word RAM with a fixed number of wait states, byte-lane writes,
// a side preload port and a whole-array synchronous clear.
module avalon_wait_ram #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_wait_ram_if.slave        bus,
    input  logic [31:0]             instruction,
    input  logic                    inst_input,
    input  logic [7:0]              inst_addr,
    input  logic                    ram_clear
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         readdata_q, readdata_d;
    logic [31:0]         mem_q [DEPTH];

    logic                req, hold, rd_only, load_rd, commit;
    logic [ADDR_W-1:0]   word, pre_word;
    logic                unused_bits;

    assign req         = bus.read | bus.write;
    assign hold        = inst_input | ram_clear;
    assign rd_only     = bus.read & ~bus.write;
    assign word        = bus.address[ADDR_W+1:2];
    assign pre_word    = ADDR_W'(inst_addr[7:2]);
    assign unused_bits = ^{bus.address[1:0], bus.address[31:ADDR_W+2], inst_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hold) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state_d = READY;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                BUSY: begin
                    // A master dropping its request mid-stall abandons the transfer.
                    if (!req)              state_d = IDLE;
                    else if (cnt_q == '0)  state_d = READY;
                    else                   cnt_d   = cnt_q - 4'd1;
                end
                READY:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.waitrequest = hold | (req & (state_q != READY));
        bus.readdata    = readdata_q;
        load_rd         = rd_only & (state_q != READY) & (state_d == READY);
        commit          = bus.write & (state_q == READY) & ~hold;
        // Array read here yields the pre-write word when a commit shares the edge.
        readdata_d      = load_rd ? mem_q[word] : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (ram_clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[ADDR_W'(i)] <= '0;
        end else if (inst_input) begin
            mem_q[pre_word] <= instruction;
        end else if (commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) mem_q[word][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed bench for avalon_wait_ram: one instance with two wait states and
// one with none, sharing address/data/preload/clear but with separate requests.
module tb_avalon_wait_ram;

    logic        clk;
    logic        reset;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] instruction;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic        ram_clear;

    int errors = 0;
    int checks = 0;

    int          nw;
    logic [31:0] rdat;

    avalon_wait_ram_if if2 ();
    avalon_wait_ram_if if0 ();

    assign if2.address    = addr;
    assign if2.writedata  = wdata;
    assign if2.byteenable = be;
    assign if2.read       = rd2;
    assign if2.write      = wr2;
    assign if0.address    = addr;
    assign if0.writedata  = wdata;
    assign if0.byteenable = be;
    assign if0.read       = rd0;
    assign if0.write      = wr0;

    avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave),
        .instruction(instruction), .inst_input(inst_input),
        .inst_addr(inst_addr), .ram_clear(ram_clear)
    );

    avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave),
        .instruction(instruction), .inst_input(inst_input),
        .inst_addr(inst_addr), .ram_clear(ram_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request already asserted; counts stalled cycles, captures readdata in the
    // cycle waitrequest falls, and returns just after the closing edge.
    task automatic wait_done(input bit sel, output int n, output logic [31:0] d);
        bit done = 1'b0;
        n = 0;
        d = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!(sel ? if0.waitrequest : if2.waitrequest)) begin
                done = 1'b1;
                break;
            end
            n++;
            @(posedge clk); #1;
        end
        if (!done) n = -1;
        d = sel ? if0.readdata : if2.readdata;
        @(posedge clk); #1;
    endtask

    task automatic xfer(input bit sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        output int n, output logic [31:0] d);
        addr  = a;
        wdata = wd;
        be    = b;
        if (sel) begin rd0 = r; wr0 = w; end
        else     begin rd2 = r; wr2 = w; end
        wait_done(sel, n, d);
        rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        inst_addr   = a;
        instruction = d;
        inst_input  = 1'b1;
        @(posedge clk); #1;
        inst_input  = 1'b0;
    endtask

    task automatic clear_ram();
        ram_clear = 1'b1;
        @(posedge clk); #1;
        ram_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        addr = '0; wdata = '0; be = '0;
        rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        instruction = '0; inst_input = 1'b0; inst_addr = '0; ram_clear = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_rdata2", if2.readdata, 32'h0);
        check("rst_rdata0", if0.readdata, 32'h0);
        check("rst_wait2_idle", {31'b0, if2.waitrequest}, 32'h0);
        rd2 = 1'b1; #1;
        check("rst_wait2_req", {31'b0, if2.waitrequest}, 32'h1);
        rd2 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_ram();

        // Preload then read with two wait states
        preload(8'h04, 32'h24020069);
        xfer(0, 1, 0, 32'h4, 32'h0, 4'h0, nw, rdat);
        check("pre_rd_nwait", 32'(nw), 32'd3);
        check("pre_rd_data", rdat, 32'h24020069);

        // Byte-lane writes
        xfer(0, 0, 1, 32'h30, 32'h00004500, 4'b0010, nw, rdat);
        check("wr_be2_nwait", 32'(nw), 32'd3);
        xfer(0, 1, 0, 32'h30, 32'h0, 4'h0, nw, rdat);
        check("wr_be2_data", rdat, 32'h00004500);
        xfer(0, 0, 1, 32'h30, 32'hFFFFFFFF, 4'b0001, nw, rdat);
        xfer(0, 1, 0, 32'h30, 32'h0, 4'h0, nw, rdat);
        check("wr_be1_data", rdat, 32'h000045FF);
        xfer(0, 0, 1, 32'h30, 32'h0, 4'b0000, nw, rdat);
        check("wr_be0_nwait", 32'(nw), 32'd3);
        xfer(0, 1, 0, 32'h30, 32'h0, 4'h0, nw, rdat);
        check("wr_be0_data", rdat, 32'h000045FF);

        // Zero wait states, including back-to-back reads
        preload(8'h08, 32'h00000008);
        xfer(1, 1, 0, 32'h8, 32'h0, 4'h0, nw, rdat);
        check("w0_rd8_nwait", 32'(nw), 32'd1);
        check("w0_rd8_data", rdat, 32'h00000008);
        xfer(1, 1, 0, 32'h4, 32'h0, 4'h0, nw, rdat);
        check("w0_b2b_a_nwait", 32'(nw), 32'd1);
        check("w0_b2b_a_data", rdat, 32'h24020069);
        xfer(1, 1, 0, 32'h8, 32'h0, 4'h0, nw, rdat);
        check("w0_b2b_b_nwait", 32'(nw), 32'd1);
        check("w0_b2b_b_data", rdat, 32'h00000008);

        // Reset asserted while a write is stalled in BUSY
        clear_ram();
        addr = 32'h40; wdata = 32'hDEADBEEF; be = 4'hF; wr2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_rdata", if2.readdata, 32'h0);
        check("mid_rst_wait_req", {31'b0, if2.waitrequest}, 32'h1);
        wr2 = 1'b0;
        #1;
        check("mid_rst_wait_noreq", {31'b0, if2.waitrequest}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        xfer(0, 1, 0, 32'h40, 32'h0, 4'h0, nw, rdat);
        check("mid_rst_mem", rdat, 32'h0);
        check("mid_rst_rd_nwait", 32'(nw), 32'd3);

        // Preload held while a read is pending
        addr = 32'h10; rd2 = 1'b1;
        inst_addr = 8'h10; instruction = 32'hCAFEF00D; inst_input = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_wait", {31'b0, if2.waitrequest}, 32'h1);
            @(posedge clk); #1;
        end
        inst_input = 1'b0;
        wait_done(0, nw, rdat);
        rd2 = 1'b0;
        check("hold_nwait", 32'(nw), 32'd3);
        check("hold_data", rdat, 32'hCAFEF00D);

        // Address aliasing and simultaneous read+write
        xfer(0, 0, 1, 32'h1004, 32'h12345678, 4'hF, nw, rdat);
        xfer(0, 1, 0, 32'h0004, 32'h0, 4'h0, nw, rdat);
        check("alias_data", rdat, 32'h12345678);
        xfer(0, 1, 1, 32'h8, 32'hA5A5A5A5, 4'hF, nw, rdat);
        check("rw_nwait", 32'(nw), 32'd3);
        check("rw_rdata_held", rdat, 32'h12345678);
        xfer(0, 1, 0, 32'h8, 32'h0, 4'h0, nw, rdat);
        check("rw_write_done", rdat, 32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
